// File: rtl/aes_block_packer.sv
// Packs a 32-bit valid/ready word stream into 128-bit blocks for the AES-128 core,
// padding short final blocks and holding back key changes until a block boundary.
module aes_block_packer #(
  parameter int          COUNT_W  = 16,
  parameter logic [31:0] PAD_WORD = 32'h0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        s_data,
  input  logic               s_valid,
  input  logic               s_last,
  output logic               s_ready,
  input  logic [127:0]       key_in,
  input  logic               key_load,
  output logic [127:0]       blk_data,
  output logic               blk_active,
  output logic               blk_last,
  output logic [1:0]         blk_pad,
  output logic [127:0]       key_out,
  output logic [COUNT_W-1:0] blk_count
);

  typedef enum logic {KEY_IDLE, KEY_PEND} key_state_t;

  key_state_t   key_state, key_state_nxt;
  logic [1:0]   word_idx;
  logic [127:0] asm_words;
  logic [127:0] key_pend;
  logic         ready_q;
  logic         xfer;
  logic         closing;
  logic [127:0] block_nxt;
  logic         key_apply;
  logic [127:0] key_apply_val;
  logic         pend_load;

  // A pending key stalls intake only at a block boundary, so the open block finishes under the old key.
  assign s_ready = ready_q && !(key_state == KEY_PEND && word_idx == 2'd0);
  assign xfer    = s_valid && s_ready;
  assign closing = xfer && (word_idx == 2'd3 || s_last);

  always_comb begin
    block_nxt = {4{PAD_WORD}};
    for (int i = 0; i < 4; i++) begin
      if (2'(i) < word_idx)
        block_nxt[127 - 32*i -: 32] = asm_words[127 - 32*i -: 32];
      else if (2'(i) == word_idx)
        block_nxt[127 - 32*i -: 32] = s_data;
    end
  end

  always_comb begin
    key_state_nxt = key_state;
    key_apply     = 1'b0;
    key_apply_val = key_pend;
    pend_load     = 1'b0;
    case (key_state)
      KEY_IDLE: begin
        if (key_load) begin
          if (word_idx == 2'd0 && !closing) begin
            key_apply     = 1'b1;
            key_apply_val = key_in;
          end else begin
            pend_load     = 1'b1;
            key_state_nxt = KEY_PEND;
          end
        end
      end
      KEY_PEND: begin
        if (key_load)
          pend_load = 1'b1;
        // Waiting out blk_active keeps key_out steady during the emission cycle.
        if (word_idx == 2'd0 && !blk_active) begin
          key_apply     = 1'b1;
          key_apply_val = key_load ? key_in : key_pend;
          key_state_nxt = KEY_IDLE;
        end
      end
      default: key_state_nxt = KEY_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_state <= KEY_IDLE;
      key_pend  <= '0;
      key_out   <= '0;
      ready_q   <= 1'b0;
    end else begin
      key_state <= key_state_nxt;
      ready_q   <= 1'b1;
      if (pend_load)
        key_pend <= key_in;
      if (key_apply)
        key_out <= key_apply_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_idx   <= '0;
      asm_words  <= '0;
      blk_data   <= '0;
      blk_active <= 1'b0;
      blk_last   <= 1'b0;
      blk_pad    <= '0;
      blk_count  <= '0;
    end else begin
      blk_active <= closing;
      if (closing) begin
        blk_data  <= block_nxt;
        blk_pad   <= 2'd3 - word_idx;
        blk_last  <= s_last;
        blk_count <= blk_count + COUNT_W'(1);
        word_idx  <= '0;
      end else if (xfer) begin
        case (word_idx)
          2'd0:    asm_words[127:96] <= s_data;
          2'd1:    asm_words[95:64]  <= s_data;
          default: asm_words[63:32]  <= s_data;
        endcase
        word_idx <= word_idx + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_aes_block_packer.sv
// Self-checking bench for aes_block_packer: directed scenarios plus random traffic
// checked against a queue-based model of blocks, padding, counts and key timing.
`timescale 1ns/1ps
module tb_aes_block_packer;

  localparam int          CW  = 8;
  localparam logic [31:0] PAD = 32'h0;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   s_data;
  logic          s_valid;
  logic          s_last;
  logic          s_ready;
  logic [127:0]  key_in;
  logic          key_load;
  logic [127:0]  blk_data;
  logic          blk_active;
  logic          blk_last;
  logic [1:0]    blk_pad;
  logic [127:0]  key_out;
  logic [CW-1:0] blk_count;

  aes_block_packer #(.COUNT_W(CW), .PAD_WORD(PAD)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .key_in(key_in), .key_load(key_load),
    .blk_data(blk_data), .blk_active(blk_active), .blk_last(blk_last),
    .blk_pad(blk_pad), .key_out(key_out), .blk_count(blk_count)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [127:0]  data;
    logic [1:0]    pad;
    logic          last;
    logic [127:0]  key;
    logic [CW-1:0] cnt;
  } blk_t;

  blk_t         exp_q[$];
  logic [31:0]  cur_words[$];
  logic [127:0] cur_key;
  logic [127:0] latest_key = '0;
  int           model_count = 0;
  bit           pulse_due = 0;
  int           ready_low = 0;
  bit           watch_k2 = 0;
  bit           saw_k2 = 0;
  logic [127:0] k2_val = '0;

  // Model: a block takes the newest requested key as of its first word, except a
  // single-word block requested in that same cycle, which still sees the old key.
  always @(negedge clk) begin
    logic [127:0] prev_key;
    blk_t b;
    if (!rst_n) begin
      checkOutput("rst_s_ready", s_ready, 0);
      checkOutput("rst_blk_active", blk_active, 0);
      checkOutput("rst_blk_count", blk_count, 0);
      checkOutput("rst_key_out", key_out, 0);
      exp_q.delete();
      cur_words.delete();
      latest_key  = '0;
      model_count = 0;
      pulse_due   = 0;
    end else begin
      if (!s_ready) ready_low++;
      if (watch_k2 && key_out === k2_val) saw_k2 = 1;
      checkOutput("pulse_timing", blk_active, pulse_due);
      if (blk_active) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_pulse", 1, 0);
        end else begin
          b = exp_q.pop_front();
          checkOutput("blk_data", blk_data, b.data);
          checkOutput("blk_pad", blk_pad, b.pad);
          checkOutput("blk_last", blk_last, b.last);
          checkOutput("blk_key", key_out, b.key);
          checkOutput("blk_count", blk_count, b.cnt);
        end
      end
      pulse_due = 0;
      prev_key = latest_key;
      if (key_load) latest_key = key_in;
      if (s_valid && s_ready) begin
        if (cur_words.size() == 0) cur_key = s_last ? prev_key : latest_key;
        cur_words.push_back(s_data);
        if (cur_words.size() == 4 || s_last) begin
          b.data = {4{PAD}};
          for (int i = 0; i < cur_words.size(); i++) b.data[127 - 32*i -: 32] = cur_words[i];
          b.pad  = 2'(4 - cur_words.size());
          b.last = s_last;
          b.key  = cur_key;
          model_count = (model_count + 1) % (1 << CW);
          b.cnt  = CW'(model_count);
          exp_q.push_back(b);
          cur_words.delete();
          pulse_due = 1;
        end
      end
    end
  end

  // Presents one word and returns #1 after the edge that accepted it.
  task automatic applyStimulus(input logic [31:0] d, input logic last);
    bit done = 0;
    s_data  = d;
    s_last  = last;
    s_valid = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      done = s_ready;
      @(posedge clk);
      #1;
    end
    if (!done) checkOutput("handshake_timeout", 0, 1);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic loadKey(input logic [127:0] k);
    key_in   = k;
    key_load = 1'b1;
    @(posedge clk);
    #1;
    key_load = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  localparam logic [127:0] K1  = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
  localparam logic [127:0] K2  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] K5A = 128'haaaa0000_aaaa0000_aaaa0000_aaaa0000;
  localparam logic [127:0] K5B = 128'h5555ffff_5555ffff_5555ffff_5555ffff;

  initial begin
    logic [31:0] w[4];
    rst_n = 1'b0; s_data = '0; s_valid = 1'b0; s_last = 1'b0;
    key_in = '0; key_load = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_blk_data", blk_data, 0);
    checkOutput("reset_s_ready", s_ready, 0);
    rst_n = 1'b1;
    idle(1);
    checkOutput("ready_after_release", s_ready, 1);

    $display("[TB] test 1: four words back-to-back");
    applyStimulus(32'h00112233, 0);
    applyStimulus(32'h44556677, 0);
    applyStimulus(32'h8899aabb, 0);
    applyStimulus(32'hccddeeff, 0);
    checkOutput("t1_active", blk_active, 1);
    checkOutput("t1_data", blk_data, 128'h00112233_44556677_8899aabb_ccddeeff);
    checkOutput("t1_pad", blk_pad, 0);
    checkOutput("t1_count", blk_count, 1);
    idle(1);
    checkOutput("t1_single_pulse", blk_active, 0);
    checkOutput("t1_data_hold", blk_data, 128'h00112233_44556677_8899aabb_ccddeeff);

    $display("[TB] test 2: eight words continuous");
    ready_low = 0;
    for (int i = 0; i < 8; i++) applyStimulus($urandom, 0);
    idle(2);
    checkOutput("t2_ready_never_low", ready_low, 0);
    checkOutput("t2_count", blk_count, 3);

    $display("[TB] test 3: short block with padding");
    applyStimulus(32'hdeadbeef, 0);
    applyStimulus(32'hcafef00d, 1);
    checkOutput("t3_pad", blk_pad, 2);
    checkOutput("t3_last", blk_last, 1);
    checkOutput("t3_low_zero", blk_data[63:0], 0);
    checkOutput("t3_high", blk_data[127:64], 64'hdeadbeef_cafef00d);

    $display("[TB] test 4: key change mid-block");
    loadKey(K1);
    checkOutput("t4_k1_direct", key_out, K1);
    applyStimulus($urandom, 0);
    applyStimulus($urandom, 0);
    loadKey(K2);
    ready_low = 0;
    applyStimulus($urandom, 0);
    applyStimulus($urandom, 0);
    checkOutput("t4_old_key", key_out, K1);
    for (int i = 0; i < 4; i++) applyStimulus($urandom, 0);
    idle(1);
    checkOutput("t4_ready_low", ready_low >= 1, 1);
    checkOutput("t4_new_key", key_out, K2);

    $display("[TB] test 5: last key request wins");
    k2_val = K5A; saw_k2 = 0; watch_k2 = 1;
    applyStimulus($urandom, 0);
    loadKey(K5A);
    loadKey(K5B);
    for (int i = 0; i < 3; i++) applyStimulus($urandom, 0);
    idle(3);
    checkOutput("t5_key_final", key_out, K5B);
    for (int i = 0; i < 4; i++) applyStimulus($urandom, 0);
    idle(1);
    watch_k2 = 0;
    checkOutput("t5_k2_never_seen", saw_k2, 0);

    $display("[TB] test 6: reset mid-block");
    for (int i = 0; i < 3; i++) applyStimulus($urandom, 0);
    rst_n = 1'b0;
    #2;
    checkOutput("t6_async_data", blk_data, 0);
    checkOutput("t6_async_count", blk_count, 0);
    checkOutput("t6_async_key", key_out, 0);
    checkOutput("t6_async_ready", s_ready, 0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < 4; i++) begin
      w[i] = $urandom;
      applyStimulus(w[i], 0);
    end
    checkOutput("t6_fresh_block", blk_data, {w[0], w[1], w[2], w[3]});
    checkOutput("t6_count", blk_count, 1);

    $display("[TB] counter wrap with single-word blocks");
    for (int i = 0; i < 300; i++) applyStimulus($urandom, 1);
    idle(1);
    checkOutput("wrap_count", blk_count, CW'(301 % (1 << CW)));
    checkOutput("wrap_pad", blk_pad, 3);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      s_valid  = ($urandom_range(0, 9) < 7);
      s_data   = $urandom;
      s_last   = ($urandom_range(0, 4) == 0);
      key_load = ($urandom_range(0, 19) == 0);
      key_in   = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0; s_last = 1'b0; key_load = 1'b0;
    idle(5);
    checkOutput("drain_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
